// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced level into press/release/long/repeat pulses and a press count
module button_event_decoder #(
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic             level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic             repeat_pulse,
    output logic [CNT_W-1:0] press_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, LONG = 2'd2} state_t;

    localparam logic [15:0] LONG_LAST = 16'(LONG_CYCLES - 1);
    localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] hold_cnt, hold_n, hold_inc;
    logic [15:0] rep_cnt, rep_n, rep_inc;
    logic        press_n, release_n, long_n, repeat_n;

    assign hold_inc = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
    assign rep_inc  = (rep_cnt == 16'hFFFF) ? rep_cnt : rep_cnt + 16'd1;

    // next state, counters and pulse selection; release has priority over long/repeat
    always_comb begin
        state_n   = IDLE;
        hold_n    = 16'd0;
        rep_n     = 16'd0;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        case (state)
            IDLE: begin
                press_n = sig_in;
                state_n = sig_in ? HELD : IDLE;
            end
            HELD: begin
                release_n = !sig_in;
                long_n    = sig_in && (hold_cnt == LONG_LAST);
                state_n   = !sig_in ? IDLE : (long_n ? LONG : HELD);
                hold_n    = (sig_in && !long_n) ? hold_inc : 16'd0;
            end
            LONG: begin
                release_n = !sig_in;
                repeat_n  = sig_in && (rep_cnt == REP_LAST);
                state_n   = sig_in ? LONG : IDLE;
                hold_n    = sig_in ? hold_inc : 16'd0;
                rep_n     = (sig_in && !repeat_n) ? rep_inc : 16'd0;
            end
            default: state_n = IDLE;
        endcase
    end

    // every output and counter is registered; reset clears everything asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hold_cnt      <= 16'd0;
            rep_cnt       <= 16'd0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_n;
            hold_cnt      <= hold_n;
            rep_cnt       <= rep_n;
            level         <= sig_in;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
            repeat_pulse  <= repeat_n;
            if (press_n)
                press_count <= press_count + CNT_W'(1);
        end
    end
endmodule
